// File: rtl/papuf_crp_ctrl_if.sv
// rtl/papuf_crp_ctrl_if.sv - request/response handshake bundle between auth/enrollment logic and papuf_crp_ctrl
interface papuf_crp_ctrl_if #(
    parameter int CW = 16,
    parameter int RW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_challenge;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_response;
    logic [CW-1:0] rsp_challenge;
    logic [RW-1:0] rsp_unstable;

    modport master (
        output req_valid, req_challenge, rsp_ready,
        input  req_ready, rsp_valid, rsp_response, rsp_challenge, rsp_unstable
    );

    modport slave (
        input  req_valid, req_challenge, rsp_ready,
        output req_ready, rsp_valid, rsp_response, rsp_challenge, rsp_unstable
    );
endinterface

// File: rtl/papuf_crp_ctrl.sv
// rtl/papuf_crp_ctrl.sv - PUF challenge issuer / response collector; PAPUF_MAJORITY_EN enables multi-round majority voting
module papuf_crp_ctrl #(
    parameter int CW      = 16,
    parameter int RW      = 16,
    parameter int SETTLE  = 4,
    parameter int PULSE_W = 2,
    parameter int CAPTURE = 4,
    parameter int VOTES   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    papuf_crp_ctrl_if.slave  bus,
    output logic [CW-1:0]    puf_challenge,
    output logic             puf_pulse,
    input  logic [RW-1:0]    puf_response
);

`ifdef PAPUF_MAJORITY_EN
    localparam int ROUNDS = VOTES;
`else
    localparam int ROUNDS = 1;
`endif
    localparam int TMAX = (SETTLE > PULSE_W) ? ((SETTLE > CAPTURE) ? SETTLE : CAPTURE)
                                             : ((PULSE_W > CAPTURE) ? PULSE_W : CAPTURE);
    localparam int TW = $clog2(TMAX + 1);
    localparam int NW = $clog2(ROUNDS + 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, CAPT, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tmr;
    logic [NW-1:0] r_round;
    logic [RW-1:0] r_sync1;
    logic [RW-1:0] r_sync2;
    logic          r_pulse;
    logic [CW-1:0] r_puf_ch;
    logic [CW-1:0] r_rsp_ch;
    logic [RW-1:0] r_rsp_resp;
    logic          w_accept;
    logic          w_tmr_done;
    logic          w_sample;
    logic          w_last_round;

    always_comb begin
        w_next       = r_state;
        w_tmr_done   = 1'b0;
        w_accept     = 1'b0;
        w_last_round = (r_round == NW'(ROUNDS - 1));
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    w_next   = SETUP;
                end
            end
            SETUP: begin
                if (r_tmr == TW'(SETTLE - 1)) begin
                    w_tmr_done = 1'b1;
                    w_next     = PULSE;
                end
            end
            PULSE: begin
                if (r_tmr == TW'(PULSE_W - 1)) begin
                    w_tmr_done = 1'b1;
                    w_next     = CAPT;
                end
            end
            CAPT: begin
                if (r_tmr == TW'(CAPTURE - 1)) begin
                    w_tmr_done = 1'b1;
                    w_next     = w_last_round ? DONE : SETUP;
                end
            end
            DONE: begin
                if (bus.rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        w_sample = (r_state == CAPT) && w_tmr_done;
    end

    // Timer restarts on every phase change; it only runs in the timed phases.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tmr    <= '0;
            r_round  <= '0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_pulse  <= 1'b0;
            r_puf_ch <= '0;
            r_rsp_ch <= '0;
        end else begin
            r_state <= w_next;
            r_sync1 <= puf_response;
            r_sync2 <= r_sync1;
            r_pulse <= (w_next == PULSE);
            if (w_tmr_done || r_state == IDLE || r_state == DONE)
                r_tmr <= '0;
            else
                r_tmr <= r_tmr + 1'b1;
            if (w_accept) begin
                r_round  <= '0;
                r_puf_ch <= bus.req_challenge;
                r_rsp_ch <= bus.req_challenge;
            end else if (w_sample && !w_last_round) begin
                r_round <= r_round + 1'b1;
            end
        end
    end

`ifdef PAPUF_MAJORITY_EN
    localparam int VW = $clog2(VOTES + 1);

    logic [VW-1:0] r_votes [RW];
    logic [VW-1:0] w_votes [RW];
    logic [RW-1:0] w_major;
    logic [RW-1:0] w_unst;
    logic [RW-1:0] r_rsp_unst;

    always_comb begin
        for (int i = 0; i < RW; i++) begin
            w_votes[i] = r_votes[i] + VW'(r_sync2[i]);
            w_major[i] = (w_votes[i] > VW'(VOTES / 2));
            w_unst[i]  = (w_votes[i] != '0) && (w_votes[i] != VW'(VOTES));
        end
    end

    // Final verdict is taken from the counts including the last round's sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RW; i++) r_votes[i] <= '0;
            r_rsp_resp <= '0;
            r_rsp_unst <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < RW; i++) r_votes[i] <= '0;
        end else if (w_sample) begin
            for (int i = 0; i < RW; i++) r_votes[i] <= w_votes[i];
            if (w_last_round) begin
                r_rsp_resp <= w_major;
                r_rsp_unst <= w_unst;
            end
        end
    end

    assign bus.rsp_unstable = r_rsp_unst;
`else
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_rsp_resp <= '0;
        else if (w_sample)
            r_rsp_resp <= r_sync2;
    end

    assign bus.rsp_unstable = '0;
`endif

    assign bus.req_ready     = (r_state == IDLE);
    assign bus.rsp_valid     = (r_state == DONE);
    assign bus.rsp_response  = r_rsp_resp;
    assign bus.rsp_challenge = r_rsp_ch;
    assign puf_challenge     = r_puf_ch;
    assign puf_pulse         = r_pulse;

endmodule

// File: tb/tb_papuf_crp_ctrl.sv
// tb/tb_papuf_crp_ctrl.sv - scoreboard bench for papuf_crp_ctrl with a behavioural PUF array model
module tb_papuf_crp_ctrl;
    localparam int CW = 16, RW = 16, SETTLE = 4, PULSE_W = 2, CAPTURE = 4, VOTES = 5;
`ifdef PAPUF_MAJORITY_EN
    localparam int R = VOTES;
`else
    localparam int R = 1;
`endif
    localparam int T    = SETTLE + PULSE_W + CAPTURE;
    localparam int MAXR = 8;

    typedef logic [MAXR-1:0][RW-1:0] plan_t;
    typedef struct {
        logic [CW-1:0] ch;
        logic [RW-1:0] resp;
        logic [RW-1:0] unst;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] puf_challenge;
    logic          puf_pulse;
    logic [RW-1:0] puf_response;

    always #5 clk = ~clk;

    papuf_crp_ctrl_if #(.CW(CW), .RW(RW)) bus ();

    papuf_crp_ctrl #(
        .CW(CW), .RW(RW), .SETTLE(SETTLE), .PULSE_W(PULSE_W), .CAPTURE(CAPTURE), .VOTES(VOTES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .puf_challenge(puf_challenge),
        .puf_pulse    (puf_pulse),
        .puf_response (puf_response)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    plan_t plan_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // True (noise-free) response of the array for a challenge.
    function automatic logic [RW-1:0] puf_true(input logic [CW-1:0] c);
        logic [31:0] p;
        if (c == 16'h1234) return 16'hA5C3;
        p = {16'h0, c} * 32'h9E37;
        return p[23:8] ^ 16'h5A5A;
    endfunction

    function automatic exp_t expect_of(input logic [CW-1:0] c, input plan_t fl);
        exp_t          e;
        int            n;
        logic [RW-1:0] t;
        logic [RW-1:0] s;
        t = puf_true(c);
        e.ch = c;
        e.resp = '0;
        e.unst = '0;
        for (int b = 0; b < RW; b++) begin
            n = 0;
            for (int r = 0; r < R; r++) begin
                s = t ^ fl[r];
                n += int'(s[b]);
            end
            e.resp[b] = (2 * n > R);
            e.unst[b] = (n != 0) && (n != R);
        end
        return e;
    endfunction

    function automatic plan_t rand_plan();
        plan_t p;
        p = '0;
        for (int r = 0; r < MAXR; r++) p[r] = RW'($urandom & $urandom & $urandom);
        return p;
    endfunction

    // PUF array model: presents a (possibly noisy) response after each excitation pulse.
    plan_t cur_plan = '0;
    int    round_i = 0;
    logic  a_prev_ready = 1'b1;
    logic  a_prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            round_i      = 0;
            a_prev_pulse = 1'b0;
            a_prev_ready = bus.req_ready;
        end else begin
            if (a_prev_ready && !bus.req_ready) begin
                cur_plan = (plan_q.size() > 0) ? plan_q.pop_front() : '0;
                round_i  = 0;
            end
            if (puf_pulse && !a_prev_pulse) begin
                puf_response = puf_true(puf_challenge) ^ ((round_i < MAXR) ? cur_plan[round_i] : '0);
                round_i++;
            end
            a_prev_ready = bus.req_ready;
            a_prev_pulse = puf_pulse;
        end
    end

    // Monitor: tracks each accepted request, checks timing, stability and the scoreboard.
    int            acc_cyc = 0;
    int            pulse_cnt = 0;
    int            mon_round = 0;
    logic          busy = 1'b0;
    logic          m_prev_ready = 1'b1;
    logic          m_prev_valid = 1'b0;
    logic          m_prev_pulse = 1'b0;
    logic [CW-1:0] acc_ch = '0;
    logic [RW-1:0] snap_resp = '0;
    logic [RW-1:0] snap_unst = '0;
    logic [CW-1:0] snap_ch = '0;
    exp_t          m_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy         = 1'b0;
            m_prev_ready = bus.req_ready;
            m_prev_valid = 1'b0;
            m_prev_pulse = 1'b0;
        end else begin
            if (m_prev_ready && !bus.req_ready && !bus.rsp_valid) begin
                busy      = 1'b1;
                acc_cyc   = cyc;
                acc_ch    = puf_challenge;
                pulse_cnt = 0;
                mon_round = 0;
            end
            if (busy) chk("puf_challenge_held", puf_challenge, acc_ch);
            if (busy && !bus.rsp_valid) chk("busy_req_ready", bus.req_ready, 0);
            if (puf_pulse) pulse_cnt++;
            if (puf_pulse && !m_prev_pulse) begin
                chk("pulse_rise_edge", cyc - acc_cyc, SETTLE + mon_round * T);
                mon_round++;
            end
            if (bus.rsp_valid && !m_prev_valid) begin
                chk("done_latency", cyc - acc_cyc, R * T);
                snap_resp = bus.rsp_response;
                snap_unst = bus.rsp_unstable;
                snap_ch   = bus.rsp_challenge;
            end
            if (bus.rsp_valid) begin
                if (m_prev_valid) begin
                    chk("done_stable_resp", bus.rsp_response, snap_resp);
                    chk("done_stable_unst", bus.rsp_unstable, snap_unst);
                    chk("done_stable_ch", bus.rsp_challenge, snap_ch);
                end
                chk("done_req_ready", bus.req_ready, 0);
                chk("done_no_pulse", puf_pulse, 0);
                if (bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_response actual=%0h required=none", bus.rsp_response);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk("rsp_response", bus.rsp_response, m_e.resp);
                        chk("rsp_challenge", bus.rsp_challenge, m_e.ch);
                        chk("rsp_unstable", bus.rsp_unstable, m_e.unst);
                    end
                    chk("pulse_count", pulse_cnt, R * PULSE_W);
                    busy = 1'b0;
                end
            end
            m_prev_ready = bus.req_ready;
            m_prev_valid = bus.rsp_valid;
            m_prev_pulse = puf_pulse;
        end
    end

    task automatic issue(input logic [CW-1:0] ch, input plan_t fl, input bit keep, output int acc);
        int k;
        exp_q.push_back(expect_of(ch, fl));
        plan_q.push_back(fl);
        bus.req_valid     = 1'b1;
        bus.req_challenge = ch;
        acc = -1;
        for (k = 0; k < 2000; k++) begin
            if (bus.req_ready) break;
            @(negedge clk);
        end
        if (k == 2000) chk("accept_timeout", 1, 0);
        else acc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 2000; k++) begin
            if (exp_q.size() == 0 && bus.req_ready) break;
            @(negedge clk);
        end
        if (k == 2000) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int            a1, a2, k;
        plan_t         pl;
        logic [CW-1:0] c;
        bus.req_valid     = 1'b0;
        bus.req_challenge = '0;
        bus.rsp_ready     = 1'b1;
        puf_response      = '0;
        rst_n             = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_puf_pulse", puf_pulse, 0);
        chk("rst_puf_challenge", puf_challenge, 0);
        chk("rst_rsp_response", bus.rsp_response, 0);
        chk("rst_rsp_challenge", bus.rsp_challenge, 0);
        chk("rst_rsp_unstable", bus.rsp_unstable, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h1234, '0, 1'b0, a1);
        wait_idle();

        pl = '0;
        pl[0][0] = 1'b1;
        pl[1][0] = 1'b1;
        issue(16'h1234, pl, 1'b0, a1);
        wait_idle();
        pl[2][0] = 1'b1;
        issue(16'h1234, pl, 1'b0, a1);
        wait_idle();

        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        issue(16'($urandom), rand_plan(), 1'b0, a1);
        for (k = 0; k < 2000; k++) begin
            if (bus.rsp_valid) break;
            @(negedge clk);
        end
        if (k == 2000) chk("bp_valid_timeout", 1, 0);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_handshake_valid", bus.rsp_valid, 0);
        chk("bp_idle_ready", bus.req_ready, 1);
        wait_idle();

        issue(16'h1234, '0, 1'b1, a1);
        issue(16'hFFFF, '0, 1'b0, a2);
        chk("busy_accept_edge", a2 - a1, R * T + 2);
        wait_idle();

        issue(16'h1234, '0, 1'b0, a1);
        for (k = 0; k < 2000; k++) begin
            if (puf_pulse) break;
            @(negedge clk);
        end
        if (k == 2000) chk("pulse_timeout", 1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_puf_pulse", puf_pulse, 0);
        chk("midrst_puf_challenge", puf_challenge, 0);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", bus.req_ready, 1);
        void'(exp_q.pop_front());
        issue(16'($urandom), rand_plan(), 1'b0, a1);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            c = 16'($urandom);
            issue(c, rand_plan(), (i < 5), a2);
            if (i > 0) chk("stream_spacing", a2 - a1, R * T + 2);
            a1 = a2;
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
